ray_march_ctrl: RTL and testbench



---
 rtl/ray_march_pkg.sv | 30 +++
 rtl/vec3_fma_fix.sv | 31 +++
 rtl/ray_march_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_ray_march_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ray_march_pkg.sv
// ray_march_pkg: shared types and helpers for the sphere-tracing controller.
//   fix_t   : signed Q16.16 scalar
//   vec3_t  : packed {x,y,z} vector, x in [95:64], z in [31:0]
//   state_t : controller state encoding
package ray_march_pkg;

    localparam int FRAC_BITS = 16;

    typedef logic signed [31:0] fix_t;
    typedef logic [95:0]        vec3_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Extract lane idx (0 = z, 1 = y, 2 = x) from a packed vector.
    function automatic fix_t vec3_lane(input vec3_t v, input int idx);
        return v[idx*32 +: 32];
    endfunction

    // 33-bit signed sum: the extra bit makes overflow visible to the far-limit test.
    function automatic logic signed [32:0] add_wide(input fix_t a, input fix_t b);
        return {a[31], a} + {b[31], b};
    endfunction

endpackage

// File: rtl/vec3_fma_fix.sv
// vec3_fma_fix: combinational pos = origin + ((t * dir) >>> 16) on three lanes.
// Each lane forms a 64-bit signed product and keeps bits [47:16]; the add wraps.
// Ports:
//   origin : ray origin, packed {x,y,z} Q16.16
//   dir    : ray direction, same packing
//   t      : march parameter, Q16.16
//   pos    : sample position, same packing
module vec3_fma_fix
    import ray_march_pkg::*;
(
    input  vec3_t origin,
    input  vec3_t dir,
    input  fix_t  t,
    output vec3_t pos
);

    for (genvar i = 0; i < 3; i++) begin : g_lane
        fix_t               o_s;
        fix_t               d_s;
        logic signed [63:0] prod_s;
        logic               unused_s;

        assign o_s      = vec3_lane(origin, i);
        assign d_s      = vec3_lane(dir, i);
        assign prod_s   = 64'(t) * 64'(d_s);
        assign pos[i*32 +: 32] = o_s + prod_s[FRAC_BITS +: 32];
        // Bits outside the Q16.16 window are intentionally dropped.
        assign unused_s = ^{prod_s[63:FRAC_BITS+32], prod_s[FRAC_BITS-1:0]};
    end

endmodule

// File: rtl/ray_march_ctrl.sv
// ray_march_ctrl: sequential sphere-tracing controller.
// Accepts a ray, issues sample positions to the scene-distance evaluator,
// advances t by each returned distance and reports hit / t / step count.
// Optional build macro: RAY_MARCH_TIMEOUT_EN adds an 8-bit WAIT watchdog.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   ray_valid/ray_ready : ray handshake; ray_origin, ray_dir packed {x,y,z}
//   query_pos/valid     : sample position to evaluator, held through WAIT
//   query_dist/valid    : returned signed Q16.16 distance
//   res_valid/res_ready : result handshake; res_hit, res_t, res_steps, res_timeout
module ray_march_ctrl
    import ray_march_pkg::*;
#(
    parameter int   MAX_STEPS   = 64,
    parameter int   STEP_W      = 7,
    parameter fix_t EPSILON     = 32'sh0000_0041,
    parameter fix_t MAX_DIST    = 32'sh0064_0000,
    parameter int   TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ray_valid,
    output logic              ray_ready,
    input  logic [95:0]       ray_origin,
    input  logic [95:0]       ray_dir,
    output logic [95:0]       query_pos,
    output logic              query_valid,
    input  logic [31:0]       query_dist,
    input  logic              query_dist_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_hit,
    output logic [31:0]       res_t,
    output logic [STEP_W-1:0] res_steps,
    output logic              res_timeout
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_ISSUE = ISSUE;
    localparam logic [2:0] S_WAIT  = WAIT;
    localparam logic [2:0] S_STEP  = STEP;
    localparam logic [2:0] S_DONE  = DONE;

    localparam logic signed [32:0] MAX_WIDE = {MAX_DIST[31], MAX_DIST};

    logic [2:0]         state_r;
    vec3_t              origin_r;
    vec3_t              dir_r;
    fix_t               t_r;
    fix_t               d_r;
    logic [STEP_W-1:0]  steps_r;
    vec3_t              query_pos_r;
    logic               query_valid_r;
    logic               ray_ready_r;
    logic               res_valid_r;
    logic               res_hit_r;
    fix_t               res_t_r;
    logic [STEP_W-1:0]  res_steps_r;

    vec3_t              pos_s;
    logic signed [32:0] sum_s;
    logic               far_s;
    logic               hit_s;
    fix_t               t_next_s;
    logic [STEP_W-1:0]  steps_inc_s;
    logic               last_s;

    vec3_fma_fix u_fma (
        .origin (origin_r),
        .dir    (dir_r),
        .t      (t_r),
        .pos    (pos_s)
    );

    // STEP-state arithmetic: saturating t update and the termination tests.
    always_comb begin
        sum_s       = add_wide(t_r, d_r);
        far_s       = (sum_s >= MAX_WIDE);
        hit_s       = (d_r < EPSILON);
        t_next_s    = far_s ? MAX_DIST : fix_t'(sum_s[31:0]);
        steps_inc_s = steps_r + STEP_W'(1'b1);
        last_s      = (steps_inc_s == STEP_W'(MAX_STEPS));
    end

`ifdef RAY_MARCH_TIMEOUT_EN
    logic [7:0] wd_r;
    logic       res_timeout_r;
    assign res_timeout = res_timeout_r;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign res_timeout = 1'b0;
`endif

    // Controller FSM and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            origin_r      <= '0;
            dir_r         <= '0;
            t_r           <= '0;
            d_r           <= '0;
            steps_r       <= '0;
            query_pos_r   <= '0;
            query_valid_r <= 1'b0;
            ray_ready_r   <= 1'b1;
            res_valid_r   <= 1'b0;
            res_hit_r     <= 1'b0;
            res_t_r       <= '0;
            res_steps_r   <= '0;
`ifdef RAY_MARCH_TIMEOUT_EN
            wd_r          <= 8'd0;
            res_timeout_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (ray_valid && ray_ready_r) begin
                        origin_r    <= ray_origin;
                        dir_r       <= ray_dir;
                        t_r         <= '0;
                        steps_r     <= '0;
                        ray_ready_r <= 1'b0;
                        state_r     <= S_ISSUE;
                    end else begin
                        ray_ready_r <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    query_pos_r   <= pos_s;
                    query_valid_r <= 1'b1;
                    state_r       <= S_WAIT;
`ifdef RAY_MARCH_TIMEOUT_EN
                    wd_r          <= 8'd0;
`endif
                end
                S_WAIT: begin
                    if (query_dist_valid) begin
                        d_r           <= query_dist;
                        query_valid_r <= 1'b0;
                        state_r       <= S_STEP;
                    end
`ifdef RAY_MARCH_TIMEOUT_EN
                    else if (wd_r == 8'(TIMEOUT_CYC - 1)) begin
                        query_valid_r <= 1'b0;
                        res_valid_r   <= 1'b1;
                        res_hit_r     <= 1'b0;
                        res_t_r       <= t_r;
                        res_steps_r   <= steps_r;
                        res_timeout_r <= 1'b1;
                        state_r       <= S_DONE;
                    end else begin
                        wd_r <= wd_r + 8'd1;
                    end
`else
                    else begin
                        state_r <= S_WAIT;
                    end
`endif
                end
                S_STEP: begin
                    steps_r <= steps_inc_s;
                    if (hit_s) begin
                        res_hit_r <= 1'b1;
                        res_t_r   <= t_r;
                    end else if (far_s) begin
                        res_hit_r <= 1'b0;
                        res_t_r   <= MAX_DIST;
                        t_r       <= MAX_DIST;
                    end else begin
                        res_hit_r <= 1'b0;
                        res_t_r   <= t_next_s;
                        t_r       <= t_next_s;
                    end
                    if (hit_s || far_s || last_s) begin
                        res_valid_r <= 1'b1;
                        res_steps_r <= steps_inc_s;
`ifdef RAY_MARCH_TIMEOUT_EN
                        res_timeout_r <= 1'b0;
`endif
                        state_r     <= S_DONE;
                    end else begin
                        state_r <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        ray_ready_r <= 1'b1;
                        state_r     <= S_IDLE;
                    end else begin
                        res_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= S_IDLE;
                    query_valid_r <= 1'b0;
                    res_valid_r   <= 1'b0;
                    ray_ready_r   <= 1'b1;
                end
            endcase
        end
    end

    assign ray_ready   = ray_ready_r;
    assign query_pos   = query_pos_r;
    assign query_valid = query_valid_r;
    assign res_valid   = res_valid_r;
    assign res_hit     = res_hit_r;
    assign res_t       = res_t_r;
    assign res_steps   = res_steps_r;

endmodule

// File: tb/tb_ray_march_ctrl.sv
`timescale 1ns/1ps
module tb_ray_march_ctrl;
    import ray_march_pkg::*;

    localparam int STEP_W = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ray_valid = 1'b0;
    logic              ray_ready;
    logic [95:0]       ray_origin = '0;
    logic [95:0]       ray_dir = '0;
    logic [95:0]       query_pos;
    logic              query_valid;
    logic [31:0]       query_dist = '0;
    logic              query_dist_valid = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              res_hit;
    logic [31:0]       res_t;
    logic [STEP_W-1:0] res_steps;
    logic              res_timeout;

    always #5 clk = ~clk;

    ray_march_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .ray_valid        (ray_valid),
        .ray_ready        (ray_ready),
        .ray_origin       (ray_origin),
        .ray_dir          (ray_dir),
        .query_pos        (query_pos),
        .query_valid      (query_valid),
        .query_dist       (query_dist),
        .query_dist_valid (query_dist_valid),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_hit          (res_hit),
        .res_t            (res_t),
        .res_steps        (res_steps),
        .res_timeout      (res_timeout)
    );

    typedef struct packed {
        logic        hit;
        logic [31:0] t;
        logic [6:0]  steps;
        logic        tmo;
    } exp_res_t;

    exp_res_t    res_q[$];
    logic [95:0] pos_q[$];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scene models: 0 plane z=10, 1 unit sphere (on-axis), 2 constant, 3 silent.
    function automatic fix_t scene(input int mode, input logic [95:0] p, input fix_t cd);
        fix_t z;
        z = p[31:0];
        case (mode)
            0:       return 32'sh000A_0000 - z;
            1:       return ((z < 0) ? -z : z) - 32'sh0001_0000;
            default: return cd;
        endcase
    endfunction

    task automatic run_ray(input logic [95:0] o, input logic [95:0] dr, input int mode,
                           input fix_t cd, input int lat, input int exp_hold,
                           input bit chk_pos, input int bp);
        int          cyc;
        int          hold;
        bit          inq;
        bit          done;
        logic [95:0] qp;
        logic [40:0] snap;
        exp_res_t    e;
        cyc = 0; hold = 0; inq = 0; done = 0; qp = '0;
        @(negedge clk);
        chk("ray_ready_idle", 96'(ray_ready), 96'd1);
        ray_origin = o;
        ray_dir    = dr;
        ray_valid  = 1'b1;
        @(negedge clk);
        ray_valid = 1'b0;
        chk("ray_ready_busy", 96'(ray_ready), 96'd0);
        while (!done && cyc < 2000) begin
            cyc++;
            query_dist_valid = 1'b0;
            if (query_valid) begin
                if (!inq) begin
                    inq  = 1;
                    hold = 0;
                    qp   = query_pos;
                    if (chk_pos) begin
                        chk("query_left", 96'(pos_q.size() != 0), 96'd1);
                        if (pos_q.size() != 0) chk("query_pos", query_pos, pos_q.pop_front());
                    end
                end else begin
                    chk("query_pos_stable", query_pos, qp);
                end
                hold++;
                if (hold == lat) begin
                    query_dist       = scene(mode, query_pos, cd);
                    query_dist_valid = 1'b1;
                end
            end else begin
                if (inq && exp_hold > 0) chk("query_hold", 96'(hold), 96'(exp_hold));
                inq = 0;
                if (res_valid) begin
                    e    = res_q.pop_front();
                    snap = {res_hit, res_t, res_steps, res_timeout};
                    if (bp > 0) begin
                        ray_origin = 96'h1;
                        ray_valid  = 1'b1;
                        for (int k = 0; k < bp; k++) begin
                            @(negedge clk);
                            chk("bp_res_stable", 96'({res_valid, res_hit, res_t, res_steps, res_timeout}),
                                96'({1'b1, snap}));
                            chk("bp_ray_ready", 96'(ray_ready), 96'd0);
                            chk("bp_no_query", 96'(query_valid), 96'd0);
                        end
                        ray_valid = 1'b0;
                    end
                    chk("res_hit", 96'(res_hit), 96'(e.hit));
                    chk("res_t", 96'(res_t), 96'(e.t));
                    chk("res_steps", 96'(res_steps), 96'(e.steps));
                    chk("res_timeout", 96'(res_timeout), 96'(e.tmo));
                    res_ready = 1'b1;
                    @(negedge clk);
                    res_ready = 1'b0;
                    chk("res_valid_clear", 96'(res_valid), 96'd0);
                    chk("ray_ready_back", 96'(ray_ready), 96'd1);
                    done = 1;
                end
            end
            if (!done) @(negedge clk);
        end
        query_dist_valid = 1'b0;
        chk("ray_finished_in_budget", 96'(done), 96'd1);
    endtask

    initial begin
        // Reset values while rst is held.
        repeat (2) @(negedge clk);
        chk("rst_ray_ready", 96'(ray_ready), 96'd1);
        chk("rst_query_valid", 96'(query_valid), 96'd0);
        chk("rst_res_valid", 96'(res_valid), 96'd0);
        chk("rst_outputs", 96'({query_pos[31:0], res_hit, res_t, res_steps, res_timeout}), 96'd0);
        rst = 1'b0;

        // Plane z=10, combinational evaluator.
        pos_q.push_back({32'h0, 32'h0, 32'h0000_0000});
        pos_q.push_back({32'h0, 32'h0, 32'h000A_0000});
        res_q.push_back('{1'b1, 32'h000A_0000, 7'd2, 1'b0});
        run_ray(96'h0, {32'h0, 32'h0, 32'h0001_0000}, 0, 32'sh0, 1, 1, 1, 0);

        // Unit sphere, origin z=-5, latency 4.
        pos_q.push_back({32'h0, 32'h0, 32'hFFFB_0000});
        pos_q.push_back({32'h0, 32'h0, 32'hFFFF_0000});
        res_q.push_back('{1'b1, 32'h0004_0000, 7'd2, 1'b0});
        run_ray({32'h0, 32'h0, 32'hFFFB_0000}, {32'h0, 32'h0, 32'h0001_0000}, 1, 32'sh0, 4, 4, 1, 0);

        // Constant 0.5: step limit.
        res_q.push_back('{1'b0, 32'h0020_0000, 7'd64, 1'b0});
        run_ray(96'h0, {32'h0, 32'h0, 32'h0001_0000}, 2, 32'sh0000_8000, 1, 1, 0, 0);

        // Constant 30.0, all-lane positions, saturation and 10-cycle backpressure.
        pos_q.push_back({32'h0001_0000, 32'h0002_0000, 32'h0003_0000});
        pos_q.push_back({32'h0010_0000, 32'hFFFA_8000, 32'h0003_0000});
        pos_q.push_back({32'h001F_0000, 32'hFFF3_0000, 32'h0003_0000});
        pos_q.push_back({32'h002E_0000, 32'hFFEB_8000, 32'h0003_0000});
        res_q.push_back('{1'b0, 32'h0064_0000, 7'd4, 1'b0});
        run_ray({32'h0001_0000, 32'h0002_0000, 32'h0003_0000},
                {32'h0000_8000, 32'hFFFF_C000, 32'h0000_0000}, 2, 32'sh001E_0000, 1, 1, 1, 10);

        // Epsilon boundary: just below hits at once, exactly epsilon does not.
        res_q.push_back('{1'b1, 32'h0000_0000, 7'd1, 1'b0});
        run_ray(96'h0, {32'h0, 32'h0, 32'h0001_0000}, 2, 32'sh0000_0040, 1, 1, 0, 0);
        res_q.push_back('{1'b0, 32'h0000_1040, 7'd64, 1'b0});
        run_ray(96'h0, {32'h0, 32'h0, 32'h0001_0000}, 2, 32'sh0000_0041, 1, 1, 0, 0);

        // Negative distance counts as a hit.
        res_q.push_back('{1'b1, 32'h0000_0000, 7'd1, 1'b0});
        run_ray(96'h0, {32'h0, 32'h0, 32'h0001_0000}, 2, -32'sh0000_2000, 1, 1, 0, 0);

        // Reset asserted during WAIT with a silent evaluator.
        @(negedge clk);
        ray_origin = 96'h0;
        ray_dir    = {32'h0, 32'h0, 32'h0001_0000};
        ray_valid  = 1'b1;
        @(negedge clk);
        ray_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_query_valid", 96'(query_valid), 96'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_query_valid", 96'(query_valid), 96'd0);
        chk("async_rst_res_valid", 96'(res_valid), 96'd0);
        chk("async_rst_ray_ready", 96'(ray_ready), 96'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ray_ready", 96'(ray_ready), 96'd1);
        chk("post_rst_no_result", 96'(res_valid), 96'd0);

        // Normal operation after the abort restarts from a clean state.
        pos_q.push_back({32'h0, 32'h0, 32'h0000_0000});
        pos_q.push_back({32'h0, 32'h0, 32'h000A_0000});
        res_q.push_back('{1'b1, 32'h000A_0000, 7'd2, 1'b0});
        run_ray(96'h0, {32'h0, 32'h0, 32'h0001_0000}, 0, 32'sh0, 1, 1, 1, 0);

`ifdef RAY_MARCH_TIMEOUT_EN
        // Silent evaluator: watchdog fires after 255 WAIT cycles.
        res_q.push_back('{1'b0, 32'h0000_0000, 7'd0, 1'b1});
        run_ray(96'h0, {32'h0, 32'h0, 32'h0001_0000}, 3, 32'sh0, 100000, 255, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
